// File: rtl/atb_pkg.sv
// ATB trace receiver shared definitions: ID width, reserved-ID range,
// flush handshake states and small helpers used across the receiver.
package atb_pkg;

    localparam int unsigned ATB_ID_W = 8;
    localparam int unsigned CNT16_W  = 16;

    // Reserved trace IDs: the null ID and the 0x70..0x7F block
    localparam logic [ATB_ID_W-1:0] ATB_ID_RSVD_NULL = 8'h00;
    localparam logic [ATB_ID_W-1:0] ATB_ID_RSVD_LO   = 8'h70;
    localparam logic [ATB_ID_W-1:0] ATB_ID_RSVD_HI   = 8'h7F;

    // Flush handshake: IDLE may pulse afready, DONE waits for afvalid to drop
    typedef enum logic {
        FL_IDLE = 1'b0,
        FL_DONE = 1'b1
    } flush_state_e;

    // True when the ID may carry trace data
    function automatic logic atid_valid(input logic [ATB_ID_W-1:0] id);
        return (id != ATB_ID_RSVD_NULL) &&
               !((id >= ATB_ID_RSVD_LO) && (id <= ATB_ID_RSVD_HI));
    endfunction

    // 16-bit increment that sticks at all-ones
    function automatic logic [CNT16_W-1:0] sat_inc16(input logic [CNT16_W-1:0] v);
        return (v == '1) ? v : v + CNT16_W'(1);
    endfunction

endpackage

// File: rtl/atb_rx_fifo.sv
// Synchronous beat buffer for the ATB receiver.
// Ports: clk, reset (sync, active-high); push/wdata write the tail,
// pop retires the head; rdata shows the head; full/empty/count report
// occupancy. Push when full and pop when empty are ignored.
module atb_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty; difference is occupancy
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage, no reset needed: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/atb_trace_receiver.sv
// ATB trace receiver: accepts trace beats, drops reserved-ID beats (sticky
// err_id, saturating drop_cnt), buffers the rest in order and presents
// them on a valid/ready stream. afready pulses once the buffer has drained
// while afvalid is held.
// Ports: clk, reset (sync, active-high); atvalid/atready/atid/atdata/atbytes
// ATB input; afvalid/afready flush; out_valid/out_ready/out_id/out_data/
// out_bytes stream output; err_id/err_clr; drop_cnt.
// Optional: define ATB_RX_ID_FILTER_EN to add filt_en/filt_id/filt_cnt,
// which discard and count valid-ID beats that do not match filt_id.
module atb_trace_receiver
    import atb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        atvalid,
    output logic                        atready,
    input  logic [ATB_ID_W-1:0]         atid,
    input  logic [DATA_W-1:0]           atdata,
    input  logic [$clog2(DATA_W/8)-1:0] atbytes,
    input  logic                        afvalid,
    output logic                        afready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ATB_ID_W-1:0]         out_id,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(DATA_W/8)-1:0] out_bytes,
    output logic                        err_id,
    input  logic                        err_clr,
`ifdef ATB_RX_ID_FILTER_EN
    input  logic                        filt_en,
    input  logic [ATB_ID_W-1:0]         filt_id,
    output logic [CNT16_W-1:0]          filt_cnt,
`endif
    output logic [CNT16_W-1:0]          drop_cnt
);

    localparam int unsigned BYTES_W = $clog2(DATA_W/8);
    localparam int unsigned BEAT_W  = ATB_ID_W + DATA_W + BYTES_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic              accept;
    logic              id_ok;
    logic              rsvd_drop;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [BEAT_W-1:0] head;
    flush_state_e      fl_state;
    flush_state_e      fl_next;

    // Ready depends only on buffer state so the source never sees a loop
    assign atready   = !fifo_full && !reset;
    assign accept    = atvalid && atready;
    assign id_ok     = atid_valid(atid);
    assign rsvd_drop = accept && !id_ok;

`ifdef ATB_RX_ID_FILTER_EN
    logic filt_drop;

    assign filt_drop = accept && id_ok && filt_en && (atid != filt_id);
    assign push      = accept && id_ok && !filt_drop;

    // Filtered-beat counter, independent of err_id
    always_ff @(posedge clk) begin
        if (reset)          filt_cnt <= '0;
        else if (filt_drop) filt_cnt <= sat_inc16(filt_cnt);
    end
`else
    assign push = accept && id_ok;
`endif

    atb_rx_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({atid, atdata, atbytes}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head presentation; held at zero whenever nothing is offered
    assign out_valid = !fifo_empty && !reset;
    assign pop       = out_valid && out_ready;
    assign {out_id, out_data, out_bytes} = out_valid ? head : '0;

    // Sticky error and drop counter; a new reserved beat beats err_clr
    always_ff @(posedge clk) begin
        if (reset) begin
            err_id   <= 1'b0;
            drop_cnt <= '0;
        end else if (rsvd_drop) begin
            err_id   <= 1'b1;
            drop_cnt <= sat_inc16(drop_cnt);
        end else if (err_clr) begin
            err_id   <= 1'b0;
        end
    end

    // Flush state register
    always_ff @(posedge clk) begin
        if (reset) fl_state <= FL_IDLE;
        else       fl_state <= fl_next;
    end

    // Flush next-state and pulse: only on a drained buffer with no beat landing
    always_comb begin
        fl_next = fl_state;
        afready = 1'b0;
        case (fl_state)
            FL_IDLE: begin
                if (!reset && afvalid && (fifo_count == CNT_W'(0)) && !accept) begin
                    afready = 1'b1;
                    fl_next = FL_DONE;
                end
            end
            FL_DONE: begin
                if (!afvalid) fl_next = FL_IDLE;
            end
            default: fl_next = FL_IDLE;
        endcase
    end

endmodule

// File: tb/tb_atb_trace_receiver.sv
// Self-checking bench for atb_trace_receiver (DATA_W=32, FIFO_DEPTH=4).
// A queue-based reference model is checked against the DUT every cycle;
// directed scenarios add literal expectations on the emitted beat log,
// error state, counters and flush pulses.
module tb_atb_trace_receiver;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  bytes;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        atvalid = 1'b0;
    logic        atready;
    logic [7:0]  atid = 8'h00;
    logic [31:0] atdata = 32'h0;
    logic [1:0]  atbytes = 2'd0;
    logic        afvalid = 1'b0;
    logic        afready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_id;
    logic [31:0] out_data;
    logic [1:0]  out_bytes;
    logic        err_id;
    logic        err_clr = 1'b0;
    logic [15:0] drop_cnt;
`ifdef ATB_RX_ID_FILTER_EN
    logic        filt_en = 1'b0;
    logic [7:0]  filt_id = 8'h00;
    logic [15:0] filt_cnt;
`endif

    always #5 clk = ~clk;

    atb_trace_receiver #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .atvalid   (atvalid),
        .atready   (atready),
        .atid      (atid),
        .atdata    (atdata),
        .atbytes   (atbytes),
        .afvalid   (afvalid),
        .afready   (afready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .err_id    (err_id),
        .err_clr   (err_clr),
`ifdef ATB_RX_ID_FILTER_EN
        .filt_en   (filt_en),
        .filt_id   (filt_id),
        .filt_cnt  (filt_cnt),
`endif
        .drop_cnt  (drop_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input logic [7:0] id);
        return {id, ~id, id ^ 8'h5A, 8'hC3};
    endfunction

    function automatic bit is_rsvd(input logic [7:0] id);
        return (id == 8'h00) || (id >= 8'h70 && id <= 8'h7F);
    endfunction

    // Reference model state
    beat_t       mq[$];
    logic        m_err   = 1'b0;
    logic [15:0] m_drop  = 16'd0;
    logic [15:0] m_filt  = 16'd0;
    bit          m_fired = 1'b0;
    bit          chk_on  = 1'b0;
    int          m_n;
    bit          e_rdy, e_acc, e_ov, e_af, e_rsvd, e_filt;
    beat_t       nb;

    // Observed output log and flush pulse count
    logic [7:0]  emit_ids[$];
    logic [31:0] emit_data[$];
    int          af_pulses = 0;

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        if (chk_on) begin
            m_n    = mq.size();
            e_rdy  = !reset && (m_n < int'(DEPTH));
            e_acc  = atvalid && e_rdy;
            e_ov   = !reset && (m_n > 0);
            e_af   = !reset && afvalid && (m_n == 0) && !e_acc && !m_fired;
            e_rsvd = is_rsvd(atid);
            e_filt = 1'b0;
`ifdef ATB_RX_ID_FILTER_EN
            e_filt = filt_en && (atid != filt_id);
            chk("filt_cnt", 64'(filt_cnt), 64'(m_filt));
`endif
            chk("atready",   64'(atready),   64'(e_rdy));
            chk("out_valid", 64'(out_valid), 64'(e_ov));
            chk("afready",   64'(afready),   64'(e_af));
            chk("err_id",    64'(err_id),    64'(m_err));
            chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
            if (e_ov) begin
                chk("out_id",    64'(out_id),    64'(mq[0].id));
                chk("out_data",  64'(out_data),  64'(mq[0].data));
                chk("out_bytes", 64'(out_bytes), 64'(mq[0].bytes));
            end
            if (reset) begin
                chk("rst_out_id",   64'(out_id),   64'd0);
                chk("rst_out_data", 64'(out_data), 64'd0);
            end
            if (afready) af_pulses++;

            if (reset) begin
                mq.delete();
                m_err   = 1'b0;
                m_drop  = 16'd0;
                m_filt  = 16'd0;
                m_fired = 1'b0;
            end else begin
                if (e_ov && out_ready) begin
                    emit_ids.push_back(out_id);
                    emit_data.push_back(out_data);
                    void'(mq.pop_front());
                end
                if (e_acc && e_rsvd) begin
                    m_err = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end else if (err_clr) begin
                    m_err = 1'b0;
                end
                if (e_acc && !e_rsvd) begin
                    if (e_filt) begin
                        if (m_filt != 16'hFFFF) m_filt = m_filt + 16'd1;
                    end else begin
                        nb.id    = atid;
                        nb.data  = atdata;
                        nb.bytes = atbytes;
                        mq.push_back(nb);
                    end
                end
                m_fired = afvalid ? (m_fired || e_af) : 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic send(input logic [7:0] id);
        bit ok;
        int budget;
        atvalid = 1'b1;
        atid    = id;
        atdata  = mk_data(id);
        atbytes = id[1:0];
        ok      = 1'b0;
        budget  = 0;
        while (!ok && budget < 50) begin
            @(negedge clk);
            ok = atready;
            @(posedge clk);
            #1;
            budget++;
        end
        atvalid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic clear_log();
        emit_ids.delete();
        emit_data.delete();
    endtask

    logic [7:0] ids_a[4];
    logic [7:0] ids_b[5];

    initial begin
        ids_a = '{8'h01, 8'h6F, 8'h80, 8'hFF};
        ids_b = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};

        // Reset state
        @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("rst_atready",   64'(atready),   64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_afready",   64'(afready),   64'd0);
        cyc(2);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_atready", 64'(atready),  64'd1);
        chk("post_rst_drop",    64'(drop_cnt), 64'd0);
        chk("post_rst_err",     64'(err_id),   64'd0);
        cyc(1);

        // Valid IDs at the reserved-range edges pass through in order
        out_ready = 1'b1;
        clear_log();
        for (int i = 0; i < 4; i++) send(ids_a[i]);
        cyc(4);
        chk("a_count", 64'(emit_ids.size()), 64'd4);
        for (int i = 0; i < emit_ids.size() && i < 4; i++)
            chk("a_order", 64'(emit_ids[i]), 64'(ids_a[i]));
        if (emit_data.size() >= 4) begin
            chk("a_data0", 64'(emit_data[0]), 64'h01FE5BC3);
            chk("a_data3", 64'(emit_data[3]), 64'hFF00A5C3);
        end
        chk("a_err",  64'(err_id),   64'd0);
        chk("a_drop", 64'(drop_cnt), 64'd0);

        // Reserved IDs are dropped and flagged
        clear_log();
        send(8'h00);
        send(8'h75);
        cyc(3);
        chk("r_count", 64'(emit_ids.size()), 64'd0);
        chk("r_err",   64'(err_id),   64'd1);
        chk("r_drop",  64'(drop_cnt), 64'd2);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("r_err_clr", 64'(err_id), 64'd0);
        // err_clr coinciding with a reserved beat leaves the flag set
        cyc(1);
        err_clr = 1'b1;
        send(8'h7F);
        err_clr = 1'b0;
        @(negedge clk);
        chk("r_err_race", 64'(err_id),   64'd1);
        chk("r_drop3",    64'(drop_cnt), 64'd3);
        cyc(1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("r_err_clr2", 64'(err_id), 64'd0);
        cyc(1);

        // Back-pressure: fill to depth, fifth waits for a pop
        out_ready = 1'b0;
        clear_log();
        for (int i = 0; i < 4; i++) send(ids_b[i]);
        @(negedge clk);
        chk("bp_full_atready", 64'(atready), 64'd0);
        cyc(1);
        fork
            send(ids_b[4]);
            begin
                cyc(3);
                out_ready = 1'b1;
            end
        join
        cyc(6);
        chk("bp_count", 64'(emit_ids.size()), 64'd5);
        for (int i = 0; i < emit_ids.size() && i < 5; i++)
            chk("bp_order", 64'(emit_ids[i]), 64'(ids_b[i]));

        // Flush waits for drain, then one pulse per afvalid assertion
        out_ready = 1'b0;
        af_pulses = 0;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        afvalid = 1'b1;
        cyc(4);
        chk("fl_hold", 64'(af_pulses), 64'd0);
        out_ready = 1'b1;
        cyc(8);
        chk("fl_one", 64'(af_pulses), 64'd1);
        afvalid = 1'b0;
        cyc(1);
        afvalid = 1'b1;
        cyc(3);
        chk("fl_rearm", 64'(af_pulses), 64'd2);
        afvalid = 1'b0;
        cyc(1);
        // Acceptance in the drained cycle defers the pulse until the beat leaves
        afvalid = 1'b1;
        send(8'h40);
        cyc(4);
        chk("fl_accept", 64'(af_pulses), 64'd3);
        afvalid = 1'b0;
        cyc(1);

        // Reset with beats buffered discards them
        out_ready = 1'b0;
        clear_log();
        send(8'h51);
        send(8'h52);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_atready",   64'(atready),   64'd0);
        chk("mr_out_id",    64'(out_id),    64'd0);
        cyc(2);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_post_atready",   64'(atready),   64'd1);
        chk("mr_post_out_valid", 64'(out_valid), 64'd0);
        chk("mr_post_drop",      64'(drop_cnt),  64'd0);
        cyc(1);
        out_ready = 1'b1;
        cyc(4);
        chk("mr_no_emit", 64'(emit_ids.size()), 64'd0);

`ifdef ATB_RX_ID_FILTER_EN
        // ID filter keeps only the selected source
        clear_log();
        filt_en = 1'b1;
        filt_id = 8'h10;
        send(8'h10);
        send(8'h11);
        send(8'h10);
        cyc(4);
        chk("f_count", 64'(emit_ids.size()), 64'd2);
        for (int i = 0; i < emit_ids.size() && i < 2; i++)
            chk("f_id", 64'(emit_ids[i]), 64'h10);
        chk("f_cnt", 64'(filt_cnt), 64'd1);
        chk("f_err", 64'(err_id),   64'd0);
        filt_en = 1'b0;
        cyc(1);
`endif

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
